// File: rtl/phoenix_host_spi_pkg.sv
// Shared constants, FSM state type and status-byte helper for the host-link
// SPI status responder.
//
// Contents:
//   CMD_STATUS / CMD_RECONFIG  recognised command bytes
//   IDLE_FILL                  MISO fill pattern when there is nothing to say
//   DEF_MAGIC / DEF_VERSION / DEF_KEY  default values for the top parameters
//   spi_state_t                responder FSM state
//   status_byte()              response byte for a given status-frame byte index
package phoenix_host_spi_pkg;

    localparam logic [7:0] CMD_STATUS   = 8'h0B;
    localparam logic [7:0] CMD_RECONFIG = 8'h5A;
    localparam logic [7:0] IDLE_FILL    = 8'hFF;

    localparam logic [7:0] DEF_MAGIC    = 8'h50;
    localparam logic [7:0] DEF_VERSION  = 8'h01;
    localparam logic [7:0] DEF_KEY      = 8'hA5;

    // Byte index 0 is the command byte; the counter sticks at this value.
    localparam logic [2:0] BYTE_CNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    // Response byte shifted out during status-frame byte 'idx' (1-based after
    // the command byte). Anything past the version byte reads as zero.
    function automatic logic [7:0] status_byte(
        input logic [2:0] idx,
        input logic [7:0] magic,
        input logic [7:0] version,
        input logic [4:0] trigger,
        input logic [3:0] boot_state
    );
        logic [7:0] v;
        case (idx)
            3'd1:    v = magic;
            3'd2:    v = {3'b000, trigger};
            3'd3:    v = {4'b0000, boot_state};
            3'd4:    v = version;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser plus one registered copy for one asynchronous SPI pin.
//
// Ports:
//   clock    in   system clock
//   i_async  in   asynchronous pin
//   o_level  out  synchronised level (2nd stage)
//   o_rise   out  one-cycle pulse on a synchronised 0->1 transition
//   o_fall   out  one-cycle pulse on a synchronised 1->0 transition
//
// The flops carry no reset on purpose: after a reset they keep tracking the
// real pin, so a chip select that is already low does not look like a fresh
// falling edge once reset is released.
module spi_input_sync (
    input  logic clock,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clock) begin
        r_meta <= i_async;
        r_sync <= r_meta;
        r_prev <= r_sync;
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_status_responder.sv
// SPI mode-0 slave on the host link of the factory image. The host reads a
// boot-status frame (command 0x0B) or requests reconfiguration (command 0x5A
// followed by the key byte). All SPI pins are oversampled by the system clock.
//
// Ports:
//   clock, reset_n      system clock, synchronous active-low reset
//   spi_sclk/mosi/cs_n  host SPI pins (asynchronous)
//   spi_miso            serial response data
//   spi_miso_oe         1 = drive the MISO pad
//   bypass              1 = flash passthrough owns the bus, block held idle
//   trigger, boot_state status fields, sampled when a status byte is loaded
//   busy                1 while a transaction is in progress
//   reconfig_req        one-cycle pulse, valid reconfig frame completed
//   cmd_error           one-cycle pulse, unknown command or malformed frame
//   dbg_state           current FSM state
//
// Handshake: there is no valid/ready pair; reconfig_req and cmd_error are
// single-cycle strobes, mutually exclusive, issued one clock after the
// synchronised chip-select rise.
module spi_status_responder
    import phoenix_host_spi_pkg::*;
#(
    parameter logic [7:0] MAGIC   = DEF_MAGIC,
    parameter logic [7:0] VERSION = DEF_VERSION,
    parameter logic [7:0] KEY     = DEF_KEY
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       bypass,
    input  logic [4:0] trigger,
    input  logic [3:0] boot_state,
    output logic       busy,
    output logic       reconfig_req,
    output logic       cmd_error,
    output spi_state_t dbg_state
);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_mosi_level, w_mosi_rise, w_mosi_fall;
    logic w_cs_level,   w_cs_rise,   w_cs_fall;

    spi_input_sync u_sync_sclk (
        .clock(clock), .i_async(spi_sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_input_sync u_sync_mosi (
        .clock(clock), .i_async(spi_mosi),
        .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    spi_input_sync u_sync_cs (
        .clock(clock), .i_async(spi_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_level, w_mosi_rise, w_mosi_fall};

    spi_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_byte_cnt;
    logic [6:0] r_rx;
    logic [7:0] r_cmd;
    logic [7:0] r_arg;
    logic [7:0] r_tx;           // bits still to be presented, MSB next
    logic       r_miso;
    logic       r_reconfig_req;
    logic       r_cmd_error;
    logic       r_cs_armed;     // CS seen high since reset; gates frame start

    logic [7:0] w_rx_next;
    logic [7:0] w_cmd_eff;
    logic [2:0] w_byte_next;
    logic [7:0] w_tx_next;

    assign w_rx_next   = {r_rx, w_mosi_level};
    // On the last bit of the command byte the command is not yet in r_cmd.
    assign w_cmd_eff   = (r_state == CMD) ? w_rx_next : r_cmd;
    assign w_byte_next = (r_byte_cnt == BYTE_CNT_MAX) ? BYTE_CNT_MAX : r_byte_cnt + 3'd1;
    assign w_tx_next   = (w_cmd_eff == CMD_STATUS)
                       ? status_byte(w_byte_next, MAGIC, VERSION, trigger, boot_state)
                       : IDLE_FILL;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_bit_cnt      <= 3'd0;
            r_byte_cnt     <= 3'd0;
            r_rx           <= 7'd0;
            r_cmd          <= 8'h00;
            r_arg          <= 8'h00;
            r_tx           <= IDLE_FILL;
            r_miso         <= 1'b1;
            r_reconfig_req <= 1'b0;
            r_cmd_error    <= 1'b0;
            r_cs_armed     <= 1'b0;
        end else begin
            r_reconfig_req <= 1'b0;
            r_cmd_error    <= 1'b0;
            if (w_cs_level) begin
                r_cs_armed <= 1'b1;
            end

            if (bypass) begin
                // Passthrough owns the bus: abandon any frame silently.
                r_state    <= IDLE;
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 3'd0;
                r_tx       <= IDLE_FILL;
                r_miso     <= 1'b1;
            end else if (r_state == IDLE) begin
                // A simultaneous SCLK edge is deliberately ignored here.
                if (w_cs_fall && r_cs_armed) begin
                    r_state    <= CMD;
                    r_bit_cnt  <= 3'd0;
                    r_byte_cnt <= 3'd0;
                    r_rx       <= 7'd0;
                    r_miso     <= IDLE_FILL[7];
                    r_tx       <= {IDLE_FILL[6:0], 1'b1};
                end
            end else if (w_cs_rise) begin
                r_state <= IDLE;
                r_tx    <= IDLE_FILL;
                r_miso  <= 1'b1;
                if (r_state == CMD) begin
                    r_cmd_error <= 1'b1;
                end else if (r_cmd == CMD_STATUS) begin
                    // Status reads may stop anywhere.
                end else if (r_cmd == CMD_RECONFIG && r_byte_cnt == 3'd2 &&
                             r_bit_cnt == 3'd0 && r_arg == KEY) begin
                    r_reconfig_req <= 1'b1;
                end else begin
                    r_cmd_error <= 1'b1;
                end
            end else if (w_sclk_rise) begin
                r_rx <= w_rx_next[6:0];
                if (r_bit_cnt == 3'd7) begin
                    r_bit_cnt  <= 3'd0;
                    r_byte_cnt <= w_byte_next;
                    // Next byte is staged now; the coming SCLK fall presents its MSB.
                    r_tx       <= w_tx_next;
                    if (r_state == CMD) begin
                        r_cmd   <= w_rx_next;
                        r_state <= DATA;
                    end
                    if (r_byte_cnt == 3'd1) begin
                        r_arg <= w_rx_next;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else if (w_sclk_fall) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b1};
            end
        end
    end

    assign spi_miso     = r_miso;
    assign spi_miso_oe  = (r_state != IDLE);
    assign busy         = (r_state != IDLE);
    assign reconfig_req = r_reconfig_req;
    assign cmd_error    = r_cmd_error;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_spi_status_responder.sv
// Directed bench for spi_status_responder: mode-0 host frames at clock/8,
// expected MISO bytes and strobe counts worked out by hand per scenario.
module tb_spi_status_responder;
    import phoenix_host_spi_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic       clock = 1'b0;
    logic       reset_n;
    logic       spi_sclk, spi_mosi, spi_cs_n;
    logic       spi_miso, spi_miso_oe;
    logic       bypass;
    logic [4:0] trigger;
    logic [3:0] boot_state;
    logic       busy, reconfig_req, cmd_error;
    spi_state_t dbg_state;

    always #20 clock = ~clock;

    spi_status_responder dut (
        .clock(clock), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .bypass(bypass), .trigger(trigger), .boot_state(boot_state),
        .busy(busy), .reconfig_req(reconfig_req), .cmd_error(cmd_error),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] mosi_bytes [8];
    logic [7:0] miso_bytes [8];
    logic [7:0] exp_q [$];

    // Cumulative cycle counts of output activity; tests compare deltas.
    int rec_cnt = 0, err_cnt = 0, busy_cnt = 0, oe_cnt = 0;
    always @(negedge clock) begin
        if (reconfig_req === 1'b1) rec_cnt++;
        if (cmd_error === 1'b1)    err_cnt++;
        if (busy === 1'b1)         busy_cnt++;
        if (spi_miso_oe === 1'b1)  oe_cnt++;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic clocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        for (int i = 0; i < 8; i++) begin
            mosi_bytes[i] = 8'h00;
            miso_bytes[i] = 8'h00;
        end
        mosi_bytes[0] = b0;
        mosi_bytes[1] = b1;
        mosi_bytes[2] = b2;
    endtask

    // Mode 0: MOSI set with SCLK low, MISO captured just before SCLK rises.
    task automatic spi_bits(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            spi_mosi = mosi_bytes[k / 8][7 - (k % 8)];
            clocks(4);
            miso_bytes[k / 8][7 - (k % 8)] = spi_miso;
            spi_sclk = 1'b1;
            clocks(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_end();
        clocks(4);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        clocks(10);
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        clocks(5);
        reset_n = 1'b1;
        clocks(5);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n    = 1'b0;
        spi_sclk   = 1'b0;
        spi_mosi   = 1'b0;
        spi_cs_n   = 1'b1;
        bypass     = 1'b0;
        trigger    = 5'd0;
        boot_state = 4'd0;
        clocks(5);
        checks++; if (spi_miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (reconfig_req !== 1'b0) begin failures++; $display("FAIL reset_reconfig got=%b exp=0", reconfig_req); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL reset_cmd_error got=%b exp=0", cmd_error); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        reset_n = 1'b1;
        clocks(5);
    endtask

    task automatic test_status();
        int rec0, err0;
        logic [7:0] exp;
        trigger    = 5'b00100;
        boot_state = 4'h3;
        set_frame(8'h0B, 8'h00, 8'h00);
        rec0 = rec_cnt; err0 = err_cnt;
        spi_cs_n = 1'b0;
        clocks(2);
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL status_oe_early got=%b exp=0", spi_miso_oe); end
        clocks(1);
        checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL status_oe_3clk got=%b exp=1", spi_miso_oe); end
        spi_bits(0, 40);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL status_busy got=%b exp=1", busy); end
        frame_end();
        exp_q = {8'hFF, 8'h50, 8'h04, 8'h03, 8'h01};
        for (int b = 0; b < 5; b++) begin
            exp = exp_q.pop_front();
            checks++;
            if (miso_bytes[b] !== exp) begin
                failures++; $display("FAIL status_byte%0d got=%02h exp=%02h", b, miso_bytes[b], exp);
            end
        end
        checks++; if (rec_cnt - rec0 != 0) begin failures++; $display("FAIL status_reconfig got=%0d exp=0", rec_cnt - rec0); end
        checks++; if (err_cnt - err0 != 0) begin failures++; $display("FAIL status_err got=%0d exp=0", err_cnt - err0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL status_busy_end got=%b exp=0", busy); end
    endtask

    // nbits: 15 missing bit, 16 exact, 17 extra bit.
    task automatic test_reconfig(input logic [7:0] key, input int nbits,
                                 input int exp_rec, input int exp_err);
        int rec0, err0;
        set_frame(8'h5A, key, 8'h00);
        rec0 = rec_cnt; err0 = err_cnt;
        spi_cs_n = 1'b0;
        spi_bits(0, nbits);
        frame_end();
        checks++; if (miso_bytes[0] !== 8'hFF || miso_bytes[1][7:1] !== 7'h7F) begin
            failures++; $display("FAIL reconfig_miso key=%02h got=%02h%02h exp=FFFF", key, miso_bytes[0], miso_bytes[1]);
        end
        checks++; if (rec_cnt - rec0 != exp_rec) begin
            failures++; $display("FAIL reconfig_req key=%02h bits=%0d got=%0d exp=%0d", key, nbits, rec_cnt - rec0, exp_rec);
        end
        checks++; if (err_cnt - err0 != exp_err) begin
            failures++; $display("FAIL reconfig_err key=%02h bits=%0d got=%0d exp=%0d", key, nbits, err_cnt - err0, exp_err);
        end
    endtask

    task automatic test_unknown_cmd();
        int rec0, err0;
        set_frame(8'h77, 8'h12, 8'h34);
        rec0 = rec_cnt; err0 = err_cnt;
        spi_cs_n = 1'b0;
        spi_bits(0, 24);
        checks++; if (err_cnt - err0 != 0) begin failures++; $display("FAIL unknown_err_early got=%0d exp=0", err_cnt - err0); end
        frame_end();
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (miso_bytes[b] !== 8'hFF) begin
                failures++; $display("FAIL unknown_byte%0d got=%02h exp=FF", b, miso_bytes[b]);
            end
        end
        checks++; if (err_cnt - err0 != 1) begin failures++; $display("FAIL unknown_err got=%0d exp=1", err_cnt - err0); end
        checks++; if (rec_cnt - rec0 != 0) begin failures++; $display("FAIL unknown_reconfig got=%0d exp=0", rec_cnt - rec0); end
    endtask

    task automatic test_short_frames();
        int err0;
        // CS rise inside the command byte.
        set_frame(8'h0B, 8'h00, 8'h00);
        err0 = err_cnt;
        spi_cs_n = 1'b0;
        spi_bits(0, 5);
        frame_end();
        checks++; if (err_cnt - err0 != 1) begin failures++; $display("FAIL short_cmd_err got=%0d exp=1", err_cnt - err0); end
        // Status frame ending mid-byte is legal.
        err0 = err_cnt;
        spi_cs_n = 1'b0;
        spi_bits(0, 12);
        frame_end();
        checks++; if (miso_bytes[1][7:4] !== 4'h5) begin failures++; $display("FAIL partial_miso got=%h exp=5", miso_bytes[1][7:4]); end
        checks++; if (err_cnt - err0 != 0) begin failures++; $display("FAIL partial_err got=%0d exp=0", err_cnt - err0); end
    endtask

    task automatic test_bypass_frame();
        int rec0, err0, busy0, oe0;
        bypass = 1'b1;
        clocks(2);
        set_frame(8'h0B, 8'h00, 8'h00);
        rec0 = rec_cnt; err0 = err_cnt; busy0 = busy_cnt; oe0 = oe_cnt;
        spi_cs_n = 1'b0;
        spi_bits(0, 40);
        frame_end();
        checks++; if (oe_cnt - oe0 != 0) begin failures++; $display("FAIL bypass_oe got=%0d exp=0", oe_cnt - oe0); end
        checks++; if (busy_cnt - busy0 != 0) begin failures++; $display("FAIL bypass_busy got=%0d exp=0", busy_cnt - busy0); end
        checks++; if ((rec_cnt - rec0) + (err_cnt - err0) != 0) begin
            failures++; $display("FAIL bypass_pulses got=%0d exp=0", (rec_cnt - rec0) + (err_cnt - err0));
        end
        bypass = 1'b0;
        clocks(4);
    endtask

    task automatic test_bypass_mid();
        int rec0, err0;
        set_frame(8'h5A, 8'hA5, 8'h00);
        rec0 = rec_cnt; err0 = err_cnt;
        spi_cs_n = 1'b0;
        spi_bits(0, 12);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bypass_mid_busy_before got=%b exp=1", busy); end
        bypass = 1'b1;
        clocks(1);
        checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin
            failures++; $display("FAIL bypass_mid_idle got=busy%b/oe%b exp=busy0/oe0", busy, spi_miso_oe);
        end
        spi_bits(12, 4);
        frame_end();
        checks++; if ((rec_cnt - rec0) + (err_cnt - err0) != 0) begin
            failures++; $display("FAIL bypass_mid_pulses got=%0d exp=0", (rec_cnt - rec0) + (err_cnt - err0));
        end
        bypass = 1'b0;
        clocks(4);
    endtask

    task automatic test_reset_mid();
        int busy0, err0;
        logic [7:0] exp;
        trigger    = 5'b00100;
        boot_state = 4'h3;
        set_frame(8'h0B, 8'h00, 8'h00);
        spi_cs_n = 1'b0;
        spi_bits(0, 20);
        reset_n = 1'b0;
        clocks(1);
        checks++; if (spi_miso !== 1'b1 || spi_miso_oe !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_outputs got=miso%b/oe%b/busy%b exp=miso1/oe0/busy0", spi_miso, spi_miso_oe, busy);
        end
        checks++; if (reconfig_req !== 1'b0 || cmd_error !== 1'b0) begin
            failures++; $display("FAIL reset_mid_pulses got=rec%b/err%b exp=rec0/err0", reconfig_req, cmd_error);
        end
        clocks(1);
        reset_n = 1'b1;
        busy0 = busy_cnt; err0 = err_cnt;
        spi_bits(20, 20);
        frame_end();
        checks++; if (busy_cnt - busy0 != 0) begin failures++; $display("FAIL reset_mid_no_restart got=%0d exp=0", busy_cnt - busy0); end
        checks++; if (err_cnt - err0 != 0) begin failures++; $display("FAIL reset_mid_err got=%0d exp=0", err_cnt - err0); end
        // Fresh frame with different status inputs.
        trigger    = 5'b10011;
        boot_state = 4'hC;
        set_frame(8'h0B, 8'h00, 8'h00);
        spi_cs_n = 1'b0;
        spi_bits(0, 40);
        frame_end();
        exp_q = {8'hFF, 8'h50, 8'h13, 8'h0C, 8'h01};
        for (int b = 0; b < 5; b++) begin
            exp = exp_q.pop_front();
            checks++;
            if (miso_bytes[b] !== exp) begin
                failures++; $display("FAIL reset_mid_byte%0d got=%02h exp=%02h", b, miso_bytes[b], exp);
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp;
        trigger    = 5'b11111;
        boot_state = 4'hF;
        set_frame(8'h0B, 8'h00, 8'h00);
        spi_cs_n = 1'b0;
        spi_bits(0, 64);
        frame_end();
        exp_q = {8'hFF, 8'h50, 8'h1F, 8'h0F, 8'h01, 8'h00, 8'h00, 8'h00};
        for (int b = 0; b < 8; b++) begin
            exp = exp_q.pop_front();
            checks++;
            if (miso_bytes[b] !== exp) begin
                failures++; $display("FAIL saturate_byte%0d got=%02h exp=%02h", b, miso_bytes[b], exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_status();
        test_reconfig(8'hA5, 16, 1, 0);
        test_reconfig(8'hA4, 16, 0, 1);
        test_reconfig(8'hA5, 17, 0, 1);
        test_reconfig(8'hA5, 15, 0, 1);
        test_unknown_cmd();
        test_short_frames();
        test_bypass_frame();
        test_bypass_mid();
        test_reset_mid();
        test_saturate();
        apply_reset();
        test_reconfig(8'hA5, 16, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
